// File: rtl/lif_param_sequencer_if.sv
// Requester, loader and status signals of the LIF parameter sequencer.
// slave is the sequencer's side; master is the side that drives the requests and params_ready.
interface lif_param_sequencer_if;
    localparam int unsigned FRAME_W = 56;

    logic               req0_valid;
    logic [FRAME_W-1:0] req0_data;
    logic               req0_ready;
    logic               req1_valid;
    logic [FRAME_W-1:0] req1_data;
    logic               req1_ready;
    logic               ld_enable;
    logic               ld_load;
    logic               ld_serial;
    logic               ld_params_ready;
    logic               busy;
    logic               grant_id;
    logic               done;
    logic               done_ok;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, ld_params_ready,
        output req0_ready, req1_ready, ld_enable, ld_load, ld_serial,
               busy, grant_id, done, done_ok
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, ld_params_ready,
        input  req0_ready, req1_ready, ld_enable, ld_load, ld_serial,
               busy, grant_id, done, done_ok
    );
endinterface

// File: rtl/lif_param_sequencer.sv
// Round-robin two-port front end that serializes 56-bit parameter frames into the LIF loader.
// Optional LIF_SEQ_RETRY_EN: replay the captured frame once after a params_ready timeout.
module lif_param_sequencer #(
    parameter int unsigned GAP_CYCLES = 3,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    lif_param_sequencer_if.slave bus
);
    localparam int unsigned FRAME_W = 56;
    localparam int unsigned BIT_W   = 6;
    localparam int unsigned TMO_W   = 8;
    localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SHIFT,
        S_GAP,
        S_WAIT_RDY,
        S_DONE
    } state_e;

    state_e             state_q,      state_d;
    logic [FRAME_W-1:0] shift_q,      shift_d;
    logic [BIT_W-1:0]   bit_cnt_q,    bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q,    gap_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q,    tmo_cnt_d;
    logic               last_grant_q, last_grant_d;
    logic               grant_id_q,   grant_id_d;
    logic               done_ok_q,    done_ok_d;
    logic               done_q,       done_d;
    logic               busy_q,       busy_d;
    logic               ld_enable_q,  ld_enable_d;
    logic               ld_load_q,    ld_load_d;
    logic               ld_serial_q,  ld_serial_d;
`ifdef LIF_SEQ_RETRY_EN
    logic [FRAME_W-1:0] backup_q,     backup_d;
    logic               retried_q,    retried_d;
    logic               replay_q,     replay_d;
`endif

    logic idle_c;
    logic win0_c;
    logic win1_c;

    // Round-robin: on contention the port that did not win last time goes first.
    assign idle_c = (state_q == S_IDLE) && !reset;
    assign win0_c = bus.req0_valid && (!bus.req1_valid || last_grant_q);
    assign win1_c = bus.req1_valid && (!bus.req0_valid || !last_grant_q);

    assign bus.req0_ready = idle_c && win0_c;
    assign bus.req1_ready = idle_c && win1_c;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        done_ok_d    = done_ok_q;
`ifdef LIF_SEQ_RETRY_EN
        backup_d     = backup_q;
        retried_d    = retried_q;
        replay_d     = replay_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (win0_c || win1_c) begin
                    state_d      = S_PREAMBLE;
                    shift_d      = win1_c ? bus.req1_data : bus.req0_data;
                    grant_id_d   = win1_c;
                    last_grant_d = win1_c;
`ifdef LIF_SEQ_RETRY_EN
                    backup_d     = win1_c ? bus.req1_data : bus.req0_data;
                    retried_d    = 1'b0;
                    replay_d     = 1'b0;
`endif
                end
            end
            S_PREAMBLE: begin
                state_d   = S_SHIFT;
                bit_cnt_d = '0;
            end
            S_SHIFT: begin
                if (bit_cnt_q == LAST_BIT) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
`ifdef LIF_SEQ_RETRY_EN
                    if (replay_q) begin
                        state_d  = S_PREAMBLE;
                        replay_d = 1'b0;
                    end else begin
                        state_d   = S_WAIT_RDY;
                        tmo_cnt_d = '0;
                    end
`else
                    state_d   = S_WAIT_RDY;
                    tmo_cnt_d = '0;
`endif
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            S_WAIT_RDY: begin
                if (bus.ld_params_ready) begin
                    state_d   = S_DONE;
                    done_ok_d = 1'b1;
                end else if (tmo_cnt_q == TMO_LAST) begin
`ifdef LIF_SEQ_RETRY_EN
                    // First timeout: idle through a full gap, then replay the saved frame.
                    if (!retried_q) begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                        shift_d   = backup_q;
                        retried_d = 1'b1;
                        replay_d  = 1'b1;
                    end else begin
                        state_d   = S_DONE;
                        done_ok_d = 1'b0;
                    end
`else
                    state_d   = S_DONE;
                    done_ok_d = 1'b0;
`endif
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs follow the next state so they line up with the state they describe.
        ld_enable_d = 1'b1;
        ld_load_d   = (state_d == S_PREAMBLE) || (state_d == S_SHIFT);
        ld_serial_d = (state_d == S_SHIFT) && shift_q[FRAME_W-1];
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        if (state_d == S_SHIFT) begin
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            done_ok_q    <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            ld_enable_q  <= 1'b0;
            ld_load_q    <= 1'b0;
            ld_serial_q  <= 1'b0;
`ifdef LIF_SEQ_RETRY_EN
            backup_q     <= '0;
            retried_q    <= 1'b0;
            replay_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            done_ok_q    <= done_ok_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            ld_enable_q  <= ld_enable_d;
            ld_load_q    <= ld_load_d;
            ld_serial_q  <= ld_serial_d;
`ifdef LIF_SEQ_RETRY_EN
            backup_q     <= backup_d;
            retried_q    <= retried_d;
            replay_q     <= replay_d;
`endif
        end
    end

    assign bus.ld_enable = ld_enable_q;
    assign bus.ld_load   = ld_load_q;
    assign bus.ld_serial = ld_serial_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.done      = done_q;
    assign bus.done_ok   = done_ok_q;
endmodule

// File: tb/tb_lif_param_sequencer.sv
// Randomized bench for lif_param_sequencer: loader model, frame-level timing model and stream capture.
module tb_lif_param_sequencer;
    localparam int G  = 3;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lif_param_sequencer_if bus ();

    lif_param_sequencer #(
        .GAP_CYCLES(G),
        .TIMEOUT   (TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Loader: params_ready drops when a burst starts and rises pr_delay cycles after it ends.
    int   pr_delay = 0;
    int   fall_cnt = 0;
    logic pr_level = 1'b1;
    always @(negedge clk) begin
        if (bus.ld_load) begin
            pr_level = 1'b0;
            fall_cnt = 0;
        end else begin
            if (fall_cnt >= pr_delay) pr_level = 1'b1;
            if (fall_cnt < 100000) fall_cnt++;
        end
        bus.ld_params_ready = pr_level;
    end

    // Every new burst must follow at least G+2 low cycles of ld_load.
    int   low_run   = 0;
    bit   have_fall = 0;
    logic prev_load = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            have_fall = 0;
            low_run   = 0;
            prev_load = 1'b0;
        end else begin
            if (bus.ld_load && !prev_load && have_fall)
                check_eq("ld_load_low_run_ok", 64'(low_run >= G + 2), 64'd1);
            if (!bus.ld_load && prev_load) have_fall = 1;
            if (bus.ld_load) low_run = 0;
            else             low_run++;
            prev_load = bus.ld_load;
        end
    end

    bit model_last = 1'b1;

    function automatic logic [55:0] rand56();
        return 56'({$urandom, $urandom});
    endfunction

    // Cycle of done (counted from the handshake cycle), status and number of bursts.
    function automatic void expect_frame(input int delay, output int done_k, output bit ok,
                                         output int bursts);
        if (delay <= G + TO - 1) begin
            done_k = 59 + ((delay > G) ? delay : G);
            ok     = 1'b1;
            bursts = 1;
        end else begin
`ifdef LIF_SEQ_RETRY_EN
            done_k = (57 + 2 * G + TO) + (58 + G + TO);
            bursts = 2;
`else
            done_k = 58 + G + TO;
            bursts = 1;
`endif
            ok = 1'b0;
        end
    endfunction

    task automatic do_frame(input bit v0, input bit v1, input logic [55:0] f0,
                            input logic [55:0] f1, input int delay, output bit won);
        bit          exp_w, exp_ok, hs, got_ok, got_gid;
        logic [55:0] exp_f;
        int          exp_k, exp_b, k, bursts, done_k;
        logic        prev;
        int          blen [3];
        logic        pre  [3];
        logic [55:0] bits [3];

        exp_w = (v0 && v1) ? !model_last : v1;
        exp_f = exp_w ? f1 : f0;
        won   = exp_w;
        expect_frame(delay, exp_k, exp_ok, exp_b);
        pr_delay       = delay;
        bus.req0_valid = v0;
        bus.req0_data  = f0;
        bus.req1_valid = v1;
        bus.req1_data  = f1;

        hs = 0;
        for (int i = 0; i < 300 && !hs; i++) begin
            #1;
            if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) hs = 1;
            else @(negedge clk);
        end
        check_eq("handshake", 64'(hs), 64'd1);
        if (!hs) return;
        check_eq("ready_sel", 64'({bus.req1_ready, bus.req0_ready}), exp_w ? 64'd2 : 64'd1);
        model_last = exp_w;
        @(posedge clk);
        #1;
        if (exp_w) bus.req1_valid = 1'b0;
        else       bus.req0_valid = 1'b0;

        for (int b = 0; b < 3; b++) begin
            blen[b] = 0;
            pre[b]  = 1'b0;
            bits[b] = '0;
        end
        k = 0; bursts = 0; prev = 1'b0; done_k = 0; got_ok = 0; got_gid = 0;
        while (done_k == 0 && k < 400) begin
            @(negedge clk);
            k++;
            if (k == 1)
                check_eq("start_en_busy_load", 64'({bus.ld_enable, bus.busy, bus.ld_load}), 64'd7);
            if (bus.ld_load) begin
                if (!prev) begin
                    if (bursts < 3) begin
                        pre[bursts]  = bus.ld_serial;
                        blen[bursts] = 1;
                    end
                    bursts++;
                end else if (bursts <= 3) begin
                    blen[bursts-1]++;
                    bits[bursts-1] = {bits[bursts-1][54:0], bus.ld_serial};
                end
            end
            prev = bus.ld_load;
            if (bus.done) begin
                done_k  = k;
                got_ok  = bus.done_ok;
                got_gid = bus.grant_id;
            end
        end
        check_eq("done_cycle", 64'(done_k), 64'(exp_k));
        check_eq("done_ok",    64'(got_ok), 64'(exp_ok));
        check_eq("grant_id",   64'(got_gid), 64'(exp_w));
        check_eq("bursts",     64'(bursts), 64'(exp_b));
        for (int b = 0; b < exp_b && b < bursts && b < 3; b++) begin
            check_eq("burst_len", 64'(blen[b]), 64'd57);
            check_eq("preamble",  64'(pre[b]), 64'd0);
            check_eq("stream",    64'(bits[b]), 64'(exp_f));
        end
    endtask

    initial begin
        logic [55:0] pend0, pend1;
        bit          w, hs;
        int          r, dones;

        reset          = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", 64'({bus.ld_enable, bus.ld_load, bus.ld_serial, bus.busy,
                                       bus.grant_id, bus.done, bus.done_ok}), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("ld_enable_after_reset", 64'(bus.ld_enable), 64'd1);

        // Known host frame, loader ready immediately: done at T+62.
        do_frame(1'b1, 1'b0, 56'h05_06_02_1E_50_00_00, '0, 0, w);
        // Loader never ready: timeout path.
        do_frame(1'b1, 1'b0, rand56(), '0, 1000, w);
        // Readiness exactly on the last sampled cycle, then one cycle too late.
        do_frame(1'b0, 1'b1, '0, rand56(), G + TO - 1, w);
        do_frame(1'b1, 1'b0, rand56(), '0, G + TO, w);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Reset in the middle of shifting aborts the frame without a done.
        pr_delay       = 0;
        bus.req0_data  = rand56();
        bus.req0_valid = 1'b1;
        hs = 0;
        for (int i = 0; i < 50 && !hs; i++) begin
            #1;
            if (bus.req0_ready) hs = 1;
            else @(negedge clk);
        end
        check_eq("abort_handshake", 64'(hs), 64'd1);
        model_last = 1'b0;
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        repeat (22) @(negedge clk);
        check_eq("abort_mid_shift_load", 64'(bus.ld_load), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_load_busy_done", 64'({bus.ld_load, bus.busy, bus.done}), 64'd0);
        reset      = 1'b0;
        model_last = 1'b1;
        dones      = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check_eq("abort_no_done", 64'(dones), 64'd0);

        // Fresh config-port frame of all ones.
        do_frame(1'b0, 1'b1, '0, 56'hFF_FFFF_FFFF_FFFF, 2, w);
        bus.req1_valid = 1'b0;

        // Both ports contending for three frames.
        pend0 = rand56();
        pend1 = rand56();
        for (int i = 0; i < 3; i++) begin
            do_frame(1'b1, 1'b1, pend0, pend1, $urandom_range(0, G), w);
            if (w) pend1 = rand56();
            else   pend0 = rand56();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Random port mix and loader latency, including timeouts.
        for (int i = 0; i < 10; i++) begin
            r = $urandom_range(1, 3);
            do_frame(r[0], r[1], pend0, pend1, $urandom_range(0, G + TO + 2), w);
            if (w) pend1 = rand56();
            else   pend0 = rand56();
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
